// File: rtl/controlador_interrupciones_pkg.sv
// Shared constants for the interrupt controller: line count, register map
// and request FSM states.
package int_pkg;

  localparam int N_FUENTES = 8;

  localparam logic [1:0] DIR_MASCARA = 2'd0;
  localparam logic [1:0] DIR_PEND    = 2'd1;
  localparam logic [1:0] DIR_ENSERV  = 2'd2;
  localparam logic [1:0] DIR_CTRL    = 2'd3;

  typedef enum logic {REPOSO, PETICION} estado_t;

  function automatic logic [N_FUENTES-1:0] one_hot(input logic [2:0] idx);
    return N_FUENTES'(1) << idx;
  endfunction

endpackage

// File: rtl/controlador_interrupciones_if.sv
// Interrupt controller bus: sources, register port and cpu handshake.
// master = cpu/gestor_e_s side, slave = controller.
interface controlador_interrupciones_if #(
  parameter int ANCHO_DIR = 10
) ();
  import int_pkg::*;

  logic [N_FUENTES-1:0] fuentes;
  logic                 sel;
  logic                 we;
  logic [1:0]           reg_dir;
  logic [7:0]           wdatos;
  logic [7:0]           rdatos;
  logic                 irq;
  logic [ANCHO_DIR-1:0] vector;
  logic                 ack;
  logic                 eoi;

  modport master (
    output fuentes, sel, we, reg_dir, wdatos, ack, eoi,
    input  rdatos, irq, vector
  );

  modport slave (
    input  fuentes, sel, we, reg_dir, wdatos, ack, eoi,
    output rdatos, irq, vector
  );

endinterface

// File: rtl/controlador_interrupciones_codificador.sv
// Priority encoder: reports whether any bit is set and the lowest set index.
module codificador_prioridad
  import int_pkg::*;
(
  input  logic [N_FUENTES-1:0] i_entrada,
  output logic                 o_valido,
  output logic [2:0]           o_idx
);

  // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    o_valido = |i_entrada;
    o_idx    = '0;
    for (int i = N_FUENTES - 1; i >= 0; i--) begin
      if (i_entrada[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt controller: edge capture, mask/enable, priority, cpu request FSM.
// Define ANIDAMIENTO_INT_EN to allow strictly-higher-priority preemption.
module controlador_interrupciones
  import int_pkg::*;
#(
  parameter int                   N_FUENTES   = 8,
  parameter int                   ANCHO_DIR   = 10,
  parameter logic [ANCHO_DIR-1:0] VECTOR_BASE = 10'h3C0,
  parameter int                   VECTOR_PASO = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  controlador_interrupciones_if.slave   bus
);

  logic [N_FUENTES-1:0] r_mascara, r_pend, r_enserv, r_prev;
  logic                 r_ctrl_en;
  estado_t              r_estado;
  logic                 r_irq;
  logic [ANCHO_DIR-1:0] r_vector;
  logic [2:0]           r_idx;

  logic [N_FUENTES-1:0] w_flancos, w_w1c, w_permitidas, w_elegibles;
  logic [N_FUENTES-1:0] w_eoi_clr, w_ack_bit;
  logic                 w_wr, w_acepta;
  logic                 w_serv_valido, w_eleg_valido;
  logic [2:0]           w_serv_idx, w_eleg_idx;
  logic [ANCHO_DIR-1:0] w_vector_nuevo;

  assign w_flancos = bus.fuentes & ~r_prev;
  assign w_wr      = bus.sel & bus.we;
  assign w_w1c     = (w_wr && bus.reg_dir == DIR_PEND) ? bus.wdatos : '0;
  assign w_acepta  = (r_estado == PETICION) && bus.ack;
  assign w_ack_bit = w_acepta ? one_hot(r_idx) : '0;
  assign w_eoi_clr = (bus.eoi && w_serv_valido) ? one_hot(w_serv_idx) : '0;

  codificador_prioridad u_cod_serv (
    .i_entrada (r_enserv),
    .o_valido  (w_serv_valido),
    .o_idx     (w_serv_idx)
  );

`ifdef ANIDAMIENTO_INT_EN
  // Only lines strictly above the highest-priority in-service line may preempt.
  always_comb begin
    w_permitidas = '1;
    if (w_serv_valido) begin
      for (int i = 0; i < N_FUENTES; i++) w_permitidas[i] = (3'(i) < w_serv_idx);
    end
  end
`else
  assign w_permitidas = w_serv_valido ? '0 : '1;
`endif

  assign w_elegibles = r_pend & r_mascara & {N_FUENTES{r_ctrl_en}} & w_permitidas;

  codificador_prioridad u_cod_eleg (
    .i_entrada (w_elegibles),
    .o_valido  (w_eleg_valido),
    .o_idx     (w_eleg_idx)
  );

  assign w_vector_nuevo = VECTOR_BASE + ANCHO_DIR'(VECTOR_PASO * int'(w_eleg_idx));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mascara <= '0;
      r_pend    <= '0;
      r_enserv  <= '0;
      r_prev    <= '0;
      r_ctrl_en <= 1'b0;
    end else begin
      r_prev   <= bus.fuentes;
      // A new edge wins over both a W1C and the ack clear in the same cycle.
      r_pend   <= (r_pend & ~w_w1c & ~w_ack_bit) | w_flancos;
      r_enserv <= (r_enserv & ~w_eoi_clr) | w_ack_bit;
      if (w_wr && bus.reg_dir == DIR_MASCARA) r_mascara <= bus.wdatos;
      if (w_wr && bus.reg_dir == DIR_CTRL)    r_ctrl_en <= bus.wdatos[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= REPOSO;
      r_irq    <= 1'b0;
      r_vector <= '0;
      r_idx    <= '0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (w_eleg_valido) begin
            r_estado <= PETICION;
            r_irq    <= 1'b1;
            r_vector <= w_vector_nuevo;
            r_idx    <= w_eleg_idx;
          end
        end
        PETICION: begin
          if (bus.ack) begin
            r_estado <= REPOSO;
            r_irq    <= 1'b0;
          end
        end
        default: r_estado <= REPOSO;
      endcase
    end
  end

  always_comb begin
    bus.rdatos = '0;
    if (bus.sel) begin
      case (bus.reg_dir)
        DIR_MASCARA: bus.rdatos = r_mascara;
        DIR_PEND:    bus.rdatos = r_pend;
        DIR_ENSERV:  bus.rdatos = r_enserv;
        DIR_CTRL:    bus.rdatos = {7'b0, r_ctrl_en};
        default:     bus.rdatos = '0;
      endcase
    end
  end

  assign bus.irq    = r_irq;
  assign bus.vector = r_vector;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Self-checking bench: expected vectors queued when a source is stimulated,
// popped and compared when irq rises; register reads checked against constants.
module tb_controlador_interrupciones;
  import int_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [9:0] q_vec[$];

  controlador_interrupciones_if #(.ANCHO_DIR(10)) bus ();

  controlador_interrupciones dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #30 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] dir, input logic [7:0] dato);
    bus.sel = 1'b1; bus.we = 1'b1; bus.reg_dir = dir; bus.wdatos = dato;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0; bus.wdatos = '0;
  endtask

  task automatic read_reg(input logic [1:0] dir, output logic [7:0] dato);
    bus.sel = 1'b1; bus.we = 1'b0; bus.reg_dir = dir;
    #1;
    dato = bus.rdatos;
    bus.sel = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] dir, input logic [7:0] exp);
    logic [7:0] d;
    read_reg(dir, d);
    check(tag, d, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    bus.fuentes = bus.fuentes | m;
    @(negedge clk);
    bus.fuentes = bus.fuentes & ~m;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.eoi = 1'b1;
    @(negedge clk);
    bus.eoi = 1'b0;
  endtask

  // Waits up to 'budget' cycles for irq, then scores the vector against the queue head.
  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    logic [9:0] exp;
    while (bus.irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.irq === 1'b1) begin
      if (q_vec.size() == 0) check({tag, "_unexpected"}, 1, 0);
      else begin
        exp = q_vec.pop_front();
        check({tag, "_vector"}, bus.vector, exp);
      end
    end else begin
      check({tag, "_timeout"}, 0, 1);
    end
  endtask

  task automatic expect_quiet(input string tag, input int ciclos);
    logic visto = 1'b0;
    repeat (ciclos) begin
      @(negedge clk);
      if (bus.irq !== 1'b0) visto = 1'b1;
    end
    check(tag, visto, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    bus.fuentes = '0; bus.sel = 0; bus.we = 0; bus.reg_dir = '0; bus.wdatos = '0;
    bus.ack = 0; bus.eoi = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_irq", bus.irq, 0);
    check("rst_vector", bus.vector, 0);
    check_reg("rst_mascara", DIR_MASCARA, 8'h00);
    check_reg("rst_pend", DIR_PEND, 8'h00);
    check_reg("rst_enserv", DIR_ENSERV, 8'h00);
    check_reg("rst_ctrl", DIR_CTRL, 8'h00);

    // Single line, exact latency
    write_reg(DIR_MASCARA, 8'h08);
    write_reg(DIR_CTRL, 8'h01);
    check_reg("ctrl_rb", DIR_CTRL, 8'h01);
    bus.fuentes[3] = 1'b1;
    q_vec.push_back(10'h3CC);
    @(negedge clk);
    bus.fuentes[3] = 1'b0;
    check("t1_irq_e0", bus.irq, 0);
    check_reg("t1_pend", DIR_PEND, 8'h08);
    @(negedge clk);
    wait_irq("t1", 0);
    do_ack();
    check("t1_irq_ack", bus.irq, 0);
    check("t1_vec_hold", bus.vector, 10'h3CC);
    check_reg("t1_pend_ack", DIR_PEND, 8'h00);
    check_reg("t1_enserv", DIR_ENSERV, 8'h08);
    do_eoi();
    check_reg("t1_enserv_eoi", DIR_ENSERV, 8'h00);

    // Ack with no request outstanding is ignored
    do_ack();
    check_reg("idle_ack_enserv", DIR_ENSERV, 8'h00);
    check("idle_ack_irq", bus.irq, 0);

    // Simultaneous edges: lowest index first
    write_reg(DIR_MASCARA, 8'hFF);
    q_vec.push_back(10'h3C4);
    q_vec.push_back(10'h3D4);
    pulse(8'h22);
    wait_irq("t2a", 4);
    do_ack();
    check_reg("t2_enserv", DIR_ENSERV, 8'h02);
    expect_quiet("t2_blocked", 3);
    do_eoi();
    wait_irq("t2b", 4);
    do_ack();
    do_eoi();
    check_reg("t2_pend_done", DIR_PEND, 8'h00);

    // Masked edge stays pending until unmasked
    write_reg(DIR_MASCARA, 8'h00);
    pulse(8'h04);
    expect_quiet("t3_masked", 4);
    check_reg("t3_pend", DIR_PEND, 8'h04);
    q_vec.push_back(10'h3C8);
    write_reg(DIR_MASCARA, 8'h04);
    wait_irq("t3", 4);
    do_ack();
    do_eoi();
    // New edge and W1C on the same cycle: the edge wins
    q_vec.push_back(10'h3C8);
    bus.fuentes[2] = 1'b1;
    bus.sel = 1'b1; bus.we = 1'b1; bus.reg_dir = DIR_PEND; bus.wdatos = 8'h04;
    @(negedge clk);
    bus.fuentes[2] = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.wdatos = '0;
    check_reg("t3_set_wins", DIR_PEND, 8'h04);
    wait_irq("t3b", 4);
    do_ack();
    do_eoi();
    // Plain W1C clears
    write_reg(DIR_MASCARA, 8'h00);
    pulse(8'h40);
    check_reg("w1c_before", DIR_PEND, 8'h40);
    write_reg(DIR_PEND, 8'h40);
    check_reg("w1c_after", DIR_PEND, 8'h00);

    // Global enable gates; mask change does not withdraw a locked request
    write_reg(DIR_CTRL, 8'h00);
    write_reg(DIR_MASCARA, 8'hFF);
    pulse(8'h80);
    expect_quiet("ge_off", 3);
    q_vec.push_back(10'h3DC);
    write_reg(DIR_CTRL, 8'h01);
    wait_irq("ge_on", 4);
    write_reg(DIR_MASCARA, 8'h00);
    check("locked_irq", bus.irq, 1);
    do_ack();
    check_reg("locked_enserv", DIR_ENSERV, 8'h80);
    do_eoi();
    write_reg(DIR_MASCARA, 8'hFF);

    // Line 4 in service, line 0 arrives
    q_vec.push_back(10'h3D0);
    pulse(8'h10);
    wait_irq("t4a", 4);
    do_ack();
    check_reg("t4_enserv", DIR_ENSERV, 8'h10);
`ifdef ANIDAMIENTO_INT_EN
    q_vec.push_back(10'h3C0);
    pulse(8'h01);
    wait_irq("t4_nest", 4);
    do_ack();
    check_reg("t4_enserv_nest", DIR_ENSERV, 8'h11);
    do_eoi();
    check_reg("t4_eoi_low", DIR_ENSERV, 8'h10);
    do_eoi();
`else
    pulse(8'h01);
    expect_quiet("t4_no_nest", 5);
    q_vec.push_back(10'h3C0);
    do_eoi();
    wait_irq("t4_after_eoi", 4);
    do_ack();
    check_reg("t4_enserv_seq", DIR_ENSERV, 8'h01);
    do_eoi();
`endif
    check_reg("t4_enserv_clr", DIR_ENSERV, 8'h00);

    // Level held high requests once
    q_vec.push_back(10'h3C0);
    bus.fuentes[0] = 1'b1;
    wait_irq("t5", 4);
    do_ack();
    do_eoi();
    expect_quiet("t5_level", 6);
    bus.fuentes[0] = 1'b0;
    check_reg("t5_pend", DIR_PEND, 8'h00);

    // Async reset while a request is outstanding
    q_vec.push_back(10'h3CC);
    pulse(8'h08);
    wait_irq("t6", 4);
    pulse(8'h20);
    #5;
    reset = 1'b1;
    #1;
    check("t6_irq_rst", bus.irq, 0);
    check("t6_vec_rst", bus.vector, 0);
    check_reg("t6_mascara", DIR_MASCARA, 8'h00);
    check_reg("t6_pend", DIR_PEND, 8'h00);
    check_reg("t6_ctrl", DIR_CTRL, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    write_reg(DIR_MASCARA, 8'hFF);
    write_reg(DIR_CTRL, 8'h01);
    expect_quiet("t6_lost", 4);
    check("sb_empty", q_vec.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
